// File: rtl/count_extender.sv
`default_nettype none
// ============================================================================
// Module   : count_extender
// Purpose  : Companion of an N-bit loadable up/down counter. Samples the
//            counter's count, ud and load on every clk edge and detects
//            wrap-around. It keeps an M-bit high word and presents an
//            (M+N)-bit extended count. It also emits one-cycle pulses when
//            the count wraps up or wraps down.
// Ports    : clk        rising-edge clock (shared with the counter)
//            rst        synchronous reset, active-high
//            count_in   [N-1:0] counter output
//            ud         counter up(1)/down(0) control
//            load       counter load control
//            clr        synchronous clear of high word and sticky sat
//            ext_count  [M+N-1:0] {hi, sampled count_in}, registered
//            wrap_up    1-cycle pulse on up wrap
//            wrap_dn    1-cycle pulse on down wrap
//            sat        sticky saturation flag (tied 0 unless EXT_SAT_EN)
// Options  : EXT_SAT_EN - high word saturates at its limits instead of
//            wrapping modulo 2^M, and sat is raised when a limit is hit.
// Revision : 1.0 - initial release
// ============================================================================
module count_extender #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   count_in,
    input  logic           ud,
    input  logic           load,
    input  logic           clr,
    output logic [M+N-1:0] ext_count,
    output logic           wrap_up,
    output logic           wrap_dn,
    output logic           sat
);

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [N-1:0] c_cnt_ones = '1;
    localparam logic [M-1:0] c_hi_ones  = '1;

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_prev;
    logic           r_ud_q;
    logic           r_load_q;
    logic [M-1:0]   r_hi;
    logic [M-1:0]   w_hi_next;
    logic [M+N-1:0] r_ext;
    logic           r_up;
    logic           r_dn;
    logic           w_up;
    logic           w_dn;
    logic           w_is_up;
    logic           w_is_dn;
`ifdef EXT_SAT_EN
    logic           r_sat;
    logic           w_sat_next;
`endif

    // The counter acted on ud/load one edge before the sample now on
    // count_in, so the transition prev->cur is judged with the delayed
    // controls. Only single-step wraps count; any other jump is ignored.
    assign w_is_up =  r_ud_q && (r_prev == c_cnt_ones) && (count_in == '0);
    assign w_is_dn = !r_ud_q && (r_prev == '0) && (count_in == c_cnt_ones);

    always_comb begin
        w_state_next = r_state;
        w_hi_next    = r_hi;
        w_up         = 1'b0;
        w_dn         = 1'b0;
`ifdef EXT_SAT_EN
        w_sat_next   = r_sat;
`endif
        case (r_state)
            INIT: begin
                // First sample after reset has no valid predecessor.
                w_hi_next    = '0;
                w_state_next = TRACK;
            end
            TRACK: begin
                if (clr) begin
                    w_hi_next  = '0;
`ifdef EXT_SAT_EN
                    w_sat_next = 1'b0;
`endif
                end else if (r_load_q) begin
                    // A load sets a new base, so the high word restarts.
                    w_hi_next = '0;
                end else if (w_is_up) begin
                    w_up = 1'b1;
`ifdef EXT_SAT_EN
                    if (r_hi == c_hi_ones) begin
                        w_sat_next = 1'b1;
                    end else begin
                        w_hi_next = r_hi + M'(1);
                    end
`else
                    w_hi_next = r_hi + M'(1);
`endif
                end else if (w_is_dn) begin
                    w_dn = 1'b1;
`ifdef EXT_SAT_EN
                    if (r_hi == '0) begin
                        w_sat_next = 1'b1;
                    end else begin
                        w_hi_next = r_hi - M'(1);
                    end
`else
                    w_hi_next = r_hi - M'(1);
`endif
                end
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= INIT;
            r_prev   <= '0;
            r_ud_q   <= 1'b0;
            r_load_q <= 1'b0;
            r_hi     <= '0;
            r_ext    <= '0;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
`ifdef EXT_SAT_EN
            r_sat    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_prev   <= count_in;
            r_ud_q   <= ud;
            r_load_q <= load;
            r_hi     <= w_hi_next;
            r_ext    <= {w_hi_next, count_in};
            r_up     <= w_up;
            r_dn     <= w_dn;
`ifdef EXT_SAT_EN
            r_sat    <= w_sat_next;
`endif
        end
    end

    assign ext_count = r_ext;
    assign wrap_up   = r_up;
    assign wrap_dn   = r_dn;
`ifdef EXT_SAT_EN
    assign sat       = r_sat;
`else
    assign sat       = 1'b0;
`endif

endmodule
`default_nettype wire
